// File: rtl/seq_subtractor_64_pkg.sv
// Shared constants and types for the sliced 64-bit subtractor.
package seq_subtractor_64_pkg;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_subtractor_64_if.sv
// Request/result bundle between a requester and the sliced subtractor.
interface seq_subtractor_64_if;
  import seq_subtractor_64_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ov;

  modport master (output start, a, b, bin, input ready, done, diff, bout, ov);
  modport slave  (input start, a, b, bin, output ready, done, diff, bout, ov);

endinterface

// File: rtl/seq_subtractor_64_sub_slice.sv
// Combinational SLICE_W-bit a - b - bin with borrow out.
module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               bin_i,
  output logic [SLICE_W-1:0] diff_o,
  output logic               bout_o
);

  logic [SLICE_W:0] res;

  // One extra bit catches the borrow: any negative result wraps into the top bit.
  assign res    = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_W{1'b0}}, bin_i};
  assign diff_o = res[SLICE_W-1:0];
  assign bout_o = res[SLICE_W];

endmodule

// File: rtl/seq_subtractor_64.sv
// Multi-cycle subtractor: one SLICE-bit chunk per clock, start/done handshake.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | walking slices 0..NSLICE-1 through the shared sub_slice
// DONE  | one-cycle done pulse, results valid, ready=1 for back-to-back start
module seq_subtractor_64
  import seq_subtractor_64_pkg::*;
(
  input logic               clk,
  input logic               rst,
  seq_subtractor_64_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wdiff_q, wdiff_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ov_q, ov_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_diff;
  logic             sl_bout;

  assign sl_a = a_q[idx_q*SLICE +: SLICE];
  assign sl_b = b_q[idx_q*SLICE +: SLICE];

  sub_slice #(.SLICE_W(SLICE)) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .bin_i  (borrow_q),
    .diff_o (sl_diff),
    .bout_o (sl_bout)
  );

  assign bus.ready = (state_q != RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ov    = ov_q;

  // Next-state, operand capture, slice accumulation and result publication.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wdiff_d  = wdiff_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ov_d     = ov_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          wdiff_d  = '0;
          idx_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        wdiff_d[idx_q*SLICE +: SLICE] = sl_diff;
        borrow_d = sl_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          // Outputs move only here, so they are never seen half-written.
          state_d = DONE;
          diff_d  = wdiff_d;
          bout_d  = sl_bout;
          ov_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (wdiff_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wdiff_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ov_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wdiff_q  <= wdiff_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ov_q     <= ov_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_seq_subtractor_64.sv
// Directed bench for seq_subtractor_64 with a cycle-level arithmetic model.
module tb_seq_subtractor_64;
  import seq_subtractor_64_pkg::*;

  localparam int N = NSLICE;

  logic clk = 1'b0;
  logic rst;

  seq_subtractor_64_if bus();

  seq_subtractor_64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model: cycles left until done, pending result, and currently visible result
  int          m_cnt = 0;
  logic        acc;
  logic [63:0] m_pdiff = '0;
  logic        m_pbout = 1'b0;
  logic        m_pov   = 1'b0;
  logic [63:0] e_diff  = '0;
  logic        e_bout  = 1'b0;
  logic        e_ov    = 1'b0;
  logic        e_done  = 1'b0;

  function automatic void ref_sub(input logic [63:0] a, input logic [63:0] b, input logic bin,
                                  output logic [63:0] d, output logic bo, output logic o);
    logic [64:0] rhs;
    d   = a - b - 64'(bin);
    rhs = {1'b0, b} + 65'(bin);
    bo  = ({1'b0, a} < rhs);
    o   = (a[63] != b[63]) && (d[63] != a[63]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: acceptance when idle, result appears N cycles later.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt  = 0;
        e_diff = '0;
        e_bout = 1'b0;
        e_ov   = 1'b0;
        e_done = 1'b0;
      end else begin
        acc    = (m_cnt == 0) && bus.start;
        e_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            e_done = 1'b1;
            e_diff = m_pdiff;
            e_bout = m_pbout;
            e_ov   = m_pov;
          end
        end
        if (acc) begin
          ref_sub(bus.a, bus.b, bus.bin, m_pdiff, m_pbout, m_pov);
          m_cnt = N;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("ready", 64'(bus.ready), 64'(m_cnt == 0));
      check("done",  64'(bus.done),  64'(e_done));
      check("diff",  bus.diff,       e_diff);
      check("bout",  64'(bus.bout),  64'(e_bout));
      check("ov",    64'(bus.ov),    64'(e_ov));
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                        input int inject_at, output int lat);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (i == inject_at) begin
        bus.start = 1'b1;
        bus.a     = ~a;
        bus.b     = a;
        bus.bin   = ~bin;
      end
    end
  endtask

  logic [63:0] s_a   [5] = '{64'h0123456789ABCDEF, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                             64'h7FFFFFFFFFFFFFFF, 64'd10};
  logic [63:0] s_b   [5] = '{64'h0011223344556677, 64'h100, 64'h0,
                             64'hFFFFFFFFFFFFFFFF, 64'd10};
  logic        s_bin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] s_d   [5] = '{64'h0112233445566778, 64'hFFFFFFFFFFFFFF00, 64'hFFFFFFFFFFFFFFFE,
                             64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF};
  logic        s_bo  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        s_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat;
    int seen;
    int prev;
    bit got;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_diff",  bus.diff,       64'd0);
    check("rst_bout",  64'(bus.bout),  64'd0);
    check("rst_ov",    64'(bus.ov),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(64'd500, 64'd3, 1'b0, -1, lat);
    check("lat_500",  64'(lat),      64'd8);
    check("diff_500", bus.diff,      64'd497);
    check("bout_500", 64'(bus.bout), 64'd0);
    check("ov_500",   64'(bus.ov),   64'd0);
    @(negedge clk);

    run_op(64'd1, 64'd16, 1'b0, -1, lat);
    check("diff_1m16", bus.diff,      64'hFFFFFFFFFFFFFFF1);
    check("bout_1m16", 64'(bus.bout), 64'd1);
    check("ov_1m16",   64'(bus.ov),   64'd0);
    @(negedge clk);

    run_op(64'd0, 64'd0, 1'b1, -1, lat);
    check("diff_bin", bus.diff,      64'hFFFFFFFFFFFFFFFF);
    check("bout_bin", 64'(bus.bout), 64'd1);
    @(negedge clk);

    run_op(64'h8000000000000000, 64'd1, 1'b0, -1, lat);
    check("diff_min", bus.diff,      64'h7FFFFFFFFFFFFFFF);
    check("ov_min",   64'(bus.ov),   64'd1);
    check("bout_min", 64'(bus.bout), 64'd0);
    @(negedge clk);

    // second start and operand change mid-run must not disturb the result
    run_op(64'd1000, 64'd1, 1'b1, 3, lat);
    check("lat_ign",  64'(lat),      64'd8);
    check("diff_ign", bus.diff,      64'd998);
    check("bout_ign", 64'(bus.bout), 64'd0);
    @(negedge clk);

    // reset in the middle of a run
    bus.a     = 64'h55;
    bus.b     = 64'h11;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_done",  64'(bus.done),  64'd0);
    check("midrst_diff",  bus.diff,       64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);

    run_op(64'd10, 64'd10, 1'b0, -1, lat);
    check("diff_eq", bus.diff,      64'd0);
    check("bout_eq", 64'(bus.bout), 64'd0);
    @(negedge clk);

    // back-to-back stream with start held high
    prev      = -1;
    bus.a     = s_a[0];
    bus.b     = s_b[0];
    bus.bin   = s_bin[0];
    bus.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (bus.done) begin
          got = 1'b1;
          break;
        end
      end
      check("stream_done_seen", 64'(got), 64'd1);
      if (!got) break;
      if (prev >= 0) check("stream_gap", 64'(cyc - prev), 64'(N + 1));
      prev = cyc;
      check("stream_diff", bus.diff,      s_d[k]);
      check("stream_bout", 64'(bus.bout), 64'(s_bo[k]));
      check("stream_ov",   64'(bus.ov),   64'(s_ov[k]));
      if (k < 4) begin
        bus.a   = s_a[k+1];
        bus.b   = s_b[k+1];
        bus.bin = s_bin[k+1];
      end else begin
        bus.start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
